// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the multi-cycle control unit.
// FSM states, opcode constants, flagALU / pc_src encodings, fault codes and opcode classes.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [5:0] OP_ALU  = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_SW   = 6'd2;
  localparam logic [5:0] OP_J    = 6'd3;
  localparam logic [5:0] OP_SRL  = 6'd4;
  localparam logic [5:0] OP_SLL  = 6'd5;
  localparam logic [5:0] OP_BEQ  = 6'd6;
  localparam logic [5:0] OP_BNQ  = 6'd7;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [1:0] FA_IDLE   = 2'd0;
  localparam logic [1:0] FA_FUNCT  = 2'd1;
  localparam logic [1:0] FA_OPCODE = 2'd2;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd1;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd2;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_J,
    CL_SHIFT,
    CL_BRANCH,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational opcode-to-class decode plus the flagALU
// value the class drives during EXECUTE.
module control_decode
  import control_pkg::*;
#(
  parameter int bitsOP = 6
) (
  input  logic [bitsOP-1:0] i_op,
  output op_class_t         o_class,
  output logic [1:0]        o_flag_alu
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_op)
      bitsOP'(OP_ALU):  o_class = CL_ALU;
      bitsOP'(OP_LW):   o_class = CL_LW;
      bitsOP'(OP_SW):   o_class = CL_SW;
      bitsOP'(OP_J):    o_class = CL_J;
      bitsOP'(OP_SRL),
      bitsOP'(OP_SLL):  o_class = CL_SHIFT;
      bitsOP'(OP_BEQ),
      bitsOP'(OP_BNQ):  o_class = CL_BRANCH;
      bitsOP'(OP_HALT): o_class = CL_HALT;
      default:          o_class = CL_ILLEGAL;
    endcase
  end

  // Loads/stores borrow the FUNCT-class add for address computation.
  always_comb begin
    o_flag_alu = FA_IDLE;
    case (o_class)
      CL_ALU, CL_LW, CL_SW: o_flag_alu = FA_FUNCT;
      CL_SHIFT, CL_BRANCH:  o_flag_alu = FA_OPCODE;
      default:              o_flag_alu = FA_IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a
// ready-based memory handshake and timeout. Define ILLEGAL_TRAP_EN to halt on illegal opcodes.
module control_unit
  import control_pkg::*;
#(
  parameter int bitsOP      = 6,
  parameter int st          = 3,
  parameter int flag        = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [bitsOP-1:0] OPCODE,
  input  logic              flagBRANCH,
  input  logic              mem_ready,
  output logic [st-1:0]     State,
  output logic [flag-1:0]   flagALU,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic              rd_src,
  output logic              halted,
  output logic [1:0]        fault_code
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state, w_state_next;
  logic [bitsOP-1:0] r_op, w_dec_op;
  logic [CW-1:0]     r_wait_cnt, w_wait_next;
  logic [1:0]        r_fault_code, w_fault_next;
  op_class_t         w_class;
  logic [1:0]        w_flag_exec, w_flag_alu;
  logic              w_ready, w_timeout;

  // In DECODE the opcode is not yet captured, so decode the live field directly.
  assign w_dec_op = (r_state == S_DECODE) ? OPCODE : r_op;

  control_decode #(.bitsOP(bitsOP)) u_decode (
    .i_op       (w_dec_op),
    .o_class    (w_class),
    .o_flag_alu (w_flag_exec)
  );

  // Masking ready with reset keeps FETCH strobes quiet while reset is held.
  assign w_ready   = mem_ready & ~reset;
  assign w_timeout = (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_op         <= '0;
      r_wait_cnt   <= '0;
      r_fault_code <= FAULT_NONE;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_next;
      r_fault_code <= w_fault_next;
      if (r_state == S_DECODE) r_op <= OPCODE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    w_fault_next = r_fault_code;
    w_flag_alu   = FA_IDLE;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_INC;
    reg_write    = 1'b0;
    rd_src       = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (w_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_HALT;
          w_fault_next = FAULT_TIMEOUT;
        end else begin
          w_wait_next = r_wait_cnt + CW'(1);
        end
      end
      S_DECODE: begin
        case (w_class)
          CL_J: begin
            pc_write     = 1'b1;
            pc_src       = PC_JUMP;
            w_state_next = S_FETCH;
          end
          CL_HALT: w_state_next = S_HALT;
          CL_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            w_state_next = S_HALT;
            w_fault_next = FAULT_ILLEGAL;
`else
            w_state_next = S_FETCH;
`endif
          end
          default: w_state_next = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        w_flag_alu   = w_flag_exec;
        w_state_next = (w_class == CL_ALU || w_class == CL_SHIFT) ? S_WRITEBACK : S_MEMORY;
      end
      S_MEMORY: begin
        if (w_class == CL_BRANCH) begin
          pc_write     = flagBRANCH;
          pc_src       = PC_BRANCH;
          w_state_next = S_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = (w_class == CL_SW);
          if (w_ready) begin
            w_state_next = (w_class == CL_LW) ? S_WRITEBACK : S_FETCH;
          end else if (w_timeout) begin
            w_state_next = S_HALT;
            w_fault_next = FAULT_TIMEOUT;
          end else begin
            w_wait_next = r_wait_cnt + CW'(1);
          end
        end
      end
      S_WRITEBACK: begin
        reg_write    = 1'b1;
        rd_src       = (w_class == CL_LW);
        w_state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: w_state_next = S_FETCH;
    endcase
  end

  assign State      = st'(r_state);
  assign flagALU    = flag'(w_flag_alu);
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench; per-cycle expected output vectors are queued
// as stimulus is driven and popped when the DUT outputs are sampled.
module tb_control_unit;
  import control_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OPCODE = '0;
  logic       flagBRANCH = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] State;
  logic [1:0] flagALU, pc_src, fault_code;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, rd_src, halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  control_unit dut (
    .clock(clock), .reset(reset), .OPCODE(OPCODE), .flagBRANCH(flagBRANCH),
    .mem_ready(mem_ready), .State(State), .flagALU(flagALU), .mem_req(mem_req),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .rd_src(rd_src), .halted(halted), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  wire [15:0] obs = {State, flagALU, mem_req, mem_we, ir_write, pc_write, pc_src,
                     reg_write, rd_src, halted, fault_code};

  function automatic logic [15:0] ev(input logic [2:0] s, input logic [1:0] fa,
                                     input logic rq, input logic we, input logic ir,
                                     input logic pw, input logic [1:0] ps, input logic rw,
                                     input logic rs, input logic h, input logic [1:0] f);
    return {s, fa, rq, we, ir, pw, ps, rw, rs, h, f};
  endfunction

  function automatic logic [15:0] e_fetch(input logic rdy);
    return ev(3'd0, 2'd0, 1'b1, 1'b0, rdy, rdy, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_dec();
    return ev(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_exe(input logic [1:0] fa);
    return ev(3'd2, fa, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_mem(input logic we);
    return ev(3'd3, 2'd0, 1'b1, we, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_br(input logic taken);
    return ev(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, taken, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_wb(input logic rs);
    return ev(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, rs, 1'b0, 2'd0);
  endfunction
  function automatic logic [15:0] e_halt(input logic [1:0] f);
    return ev(3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, f);
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Called at a falling edge: drive, queue the expectation, sample 1 ns later.
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic br, input logic [15:0] want);
    mem_ready  = rdy;
    OPCODE     = op;
    flagBRANCH = br;
    exp_q.push_back(want);
    #1;
    check_eq(tag, obs, exp_q.pop_front());
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq(tag, obs, e_fetch(1'b0));
    @(negedge clock);
    #1;
    check_eq({tag, "_held"}, obs, e_fetch(1'b0));
    @(negedge clock);
    reset = 1'b0;
    $display("txn %s", tag);
  endtask

  task automatic run_rtype(input string name, input logic [5:0] op, input logic [1:0] fa);
    cyc({name, "_fetch"}, 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc({name, "_decode"}, 1'b1, op, 1'b0, e_dec());
    cyc({name, "_exec"}, 1'b1, op, 1'b0, e_exe(fa));
    cyc({name, "_wb"}, 1'b1, op, 1'b0, e_wb(1'b0));
    $display("txn %s op=%0d", name, op);
  endtask

  task automatic run_branch(input string name, input logic [5:0] op, input logic br);
    cyc({name, "_fetch"}, 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc({name, "_decode"}, 1'b1, op, 1'b0, e_dec());
    cyc({name, "_exec"}, 1'b1, op, 1'b0, e_exe(2'd2));
    cyc({name, "_mem"}, 1'b1, op, br, e_br(br));
    $display("txn %s op=%0d taken=%0d", name, op, br);
  endtask

  initial begin
    @(negedge clock);
    do_reset("reset");

    run_rtype("alu", OP_ALU, 2'd1);

    cyc("lw_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("lw_decode", 1'b1, OP_LW, 1'b0, e_dec());
    cyc("lw_exec", 1'b1, OP_LW, 1'b0, e_exe(2'd1));
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, OP_LW, 1'b0, e_mem(1'b0));
    cyc("lw_mem_done", 1'b1, OP_LW, 1'b0, e_mem(1'b0));
    cyc("lw_wb", 1'b1, OP_LW, 1'b0, e_wb(1'b1));
    $display("txn lw with 3 wait states");

    cyc("sw_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("sw_decode", 1'b1, OP_SW, 1'b0, e_dec());
    cyc("sw_exec", 1'b1, OP_SW, 1'b0, e_exe(2'd1));
    cyc("sw_mem", 1'b1, OP_SW, 1'b0, e_mem(1'b1));
    $display("txn sw");

    run_branch("beq", OP_BEQ, 1'b1);
    run_branch("bnq", OP_BNQ, 1'b0);
    run_rtype("srl", OP_SRL, 2'd2);
    run_rtype("sll", OP_SLL, 2'd2);

    cyc("j_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("j_decode", 1'b1, OP_J, 1'b0,
        ev(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0));
    $display("txn j");

    // Ready arriving on the last permitted wait cycle must win over the timeout.
    for (int i = 0; i < 15; i++) cyc("fetch_wait", 1'b0, 6'd0, 1'b0, e_fetch(1'b0));
    cyc("fetch_ready_16th", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("edge_decode", 1'b1, OP_ALU, 1'b0, e_dec());
    cyc("edge_exec", 1'b1, OP_ALU, 1'b0, e_exe(2'd1));
    cyc("edge_wb", 1'b1, OP_ALU, 1'b0, e_wb(1'b0));
    $display("txn fetch ready on 16th cycle");

    cyc("rst_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("rst_decode", 1'b1, OP_ALU, 1'b0, e_dec());
    mem_ready = 1'b1;
    #1;
    check_eq("rst_exec", obs, e_exe(2'd1));
    reset = 1'b1;
    #1;
    check_eq("reset_mid_exec", obs, e_fetch(1'b0));
    @(negedge clock);
    reset = 1'b0;
    $display("txn reset mid-execute");

    cyc("ill_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("ill_decode", 1'b1, 6'd20, 1'b0, e_dec());
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_trap", 1'b1, 6'd20, 1'b0, e_halt(2'd2));
    cyc("ill_trap_hold", 1'b1, 6'd0, 1'b0, e_halt(2'd2));
`else
    cyc("ill_nop_fetch", 1'b0, 6'd20, 1'b0, e_fetch(1'b0));
`endif
    $display("txn illegal opcode 20");
    do_reset("reset_after_illegal");

    cyc("halt_fetch", 1'b1, 6'd0, 1'b0, e_fetch(1'b1));
    cyc("halt_decode", 1'b1, OP_HALT, 1'b0, e_dec());
    cyc("halt_state", 1'b1, 6'd0, 1'b0, e_halt(2'd0));
    cyc("halt_sticky", 1'b1, 6'd0, 1'b1, e_halt(2'd0));
    $display("txn halt opcode");
    do_reset("reset_after_halt");

    for (int i = 0; i < 16; i++) cyc("timeout_wait", 1'b0, 6'd0, 1'b0, e_fetch(1'b0));
    cyc("timeout_halt", 1'b1, 6'd0, 1'b0, e_halt(2'd1));
    cyc("timeout_sticky", 1'b1, 6'd0, 1'b0, e_halt(2'd1));
    $display("txn fetch timeout");
    do_reset("reset_after_timeout");

    run_rtype("alu_after_reset", OP_ALU, 2'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle control FSM that drives the execute stage. Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. Produces the 3-bit State and 2-bit flagALU consumed by the ALU, and samples the ALU's flagBRANCH. Also drives the PC, IR, register-file and memory strobes, including a ready-based memory handshake with timeout.

Parameters:
- bitsOP, 6, opcode width
- st, 3, State width
- flag, 2, flagALU width
- MEM_TIMEOUT, 16, consecutive not-ready wait cycles before fault (>=1)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- OPCODE  input  6  opcode field of instruction register, valid from DECODE onward
- flagBRANCH  input  1  branch-taken flag from ALU
- mem_ready  input  1  memory completes current request this cycle
- State  output  3  FSM state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 5 HALT
- flagALU  output  2  0 idle, 1 FUNCT-class op, 2 OPCODE-class op
- mem_req  output  1  memory request active
- mem_we  output  1  write qualifier for mem_req
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- pc_src  output  2  0 PC+1, 1 branch target, 2 jump target
- reg_write  output  1  register-file write enable
- rd_src  output  1  0 ALU RDvalue, 1 memory data
- halted  output  1  FSM in HALT
- fault_code  output  2  0 none, 1 memory timeout, 2 illegal opcode

Behaviour:
- Reset (async, active-high): state=FETCH, op_q=0, wait_cnt=0, fault_code=0.
  - Decoded outputs during reset: State=0, mem_req=1, all others 0.
- Outputs are combinational decodes of the registered state, op_q and mem_ready. No other output registers except fault_code.
- op_q captures OPCODE on the DECODE clock edge.
- Opcode classes:
  - 0: ALU, flagALU=1
  - 1: LW
  - 2: SW
  - 3: J
  - 4, 5: shift, flagALU=2
  - 6, 7: BEQ/BNQ, flagALU=2
  - 63: HALT
  - All others: illegal.
- FETCH: mem_req=1.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - J: pc_write=1, pc_src=2, then FETCH (2 cycles total).
  - HALT: go to HALT.
  - Illegal: go to FETCH as a NOP.
  - All others: go to EXECUTE.
- EXECUTE: flagALU is driven for one cycle per class; LW/SW use flagALU=1 for address compute. The ALU registers its result at the edge leaving EXECUTE.
  - ALU/shift: go to WRITEBACK.
  - LW/SW/branch: go to MEMORY.
- MEMORY:
  - Branch: 1 cycle only. pc_write=flagBRANCH, pc_src=1, then FETCH. The ALU clears flagBRANCH itself during State=1.
  - LW/SW: mem_req=1, mem_we=(SW). Wait for mem_ready, then LW goes to WRITEBACK and SW goes to FETCH.
- WRITEBACK: reg_write=1, rd_src=(LW), then FETCH.
- Latency (zero wait states): ALU/shift 4, LW 5, SW 4, branch 4, J 2 cycles.
- Timeout:
  - wait_cnt increments on each FETCH or LW/SW MEMORY cycle with mem_ready=0.
  - It clears on mem_ready=1 or state change.
  - When a not-ready cycle occurs with wait_cnt==MEM_TIMEOUT-1: go to HALT, fault_code=1.
  - mem_ready arriving in that same cycle wins, so no fault.
- HALT: halted=1, all strobes 0, flagALU=0. Sticky until reset; fault_code holds.
- mem_ready outside FETCH/MEMORY is ignored.
- Reset mid-operation aborts immediately with no partial strobes.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT with fault_code=2.
- Undefined: an illegal opcode is a NOP (DECODE to FETCH) and fault_code never equals 2.

Decomposition:
- Shared package control_pkg holds:
  - state encodings (FETCH..HALT)
  - opcode constants (OP_ALU=0, OP_LW=1, OP_SW=2, OP_J=3, OP_SRL=4, OP_SLL=5, OP_BEQ=6, OP_BNQ=7, OP_HALT=63)
  - flagALU and pc_src encodings
  - fault codes
- One sub-module, control_decode: combinational op_q-to-class decode, reused by testbench checkers.

Test Plan:
- OPCODE=0, mem_ready=1 always -> State sequence 0,1,2,4,0; flagALU=1 only in cycle 3; reg_write=1, rd_src=0 in cycle 4.
- OPCODE=1, mem_ready low for 3 cycles in MEMORY -> mem_req=1, mem_we=0 held 4 cycles; then WRITEBACK with rd_src=1; no fault.
- OPCODE=6 with flagBRANCH=1, then OPCODE=7 with flagBRANCH=0 -> pc_write=1, pc_src=1 in first MEMORY; pc_write=0 in second.
- mem_ready held 0 in FETCH -> after exactly 16 wait cycles: State=5, halted=1, fault_code=1; mem_ready=1 on 16th cycle -> DECODE, no fault.
- OPCODE=3 -> pc_src=2, pc_write=1 in DECODE, back to FETCH next cycle; OPCODE=63 -> HALT, halted=1, fault_code=0.
- OPCODE=20 -> with ILLEGAL_TRAP_EN: HALT, fault_code=2; without: FETCH next cycle, fault_code=0. Reset asserted mid-EXECUTE -> State=0 immediately.
